// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM voice bank.
package pwm_pkg;

   localparam int unsigned NUM_VOICES  = 8;
   localparam int unsigned CTRL_W      = 16;
   localparam int unsigned EN_BIT      = 15;
   localparam int unsigned HP_MSB      = 14;
   localparam int unsigned HP_LSB      = 0;
   localparam int unsigned HP_W        = HP_MSB - HP_LSB + 1;
   localparam int unsigned LEVEL_W     = 4;
   localparam int unsigned FRAME_SLOTS = 8;

   // A control word only produces a tone when enabled with a non-zero half-period.
   function automatic logic ctrl_active(input logic [CTRL_W-1:0] c);
      return c[EN_BIT] && (c[HP_MSB:HP_LSB] != '0);
   endfunction

   // Number of voices currently high.
   function automatic logic [LEVEL_W-1:0] count_high(input logic [NUM_VOICES-1:0] v);
      logic [LEVEL_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
         n = n + LEVEL_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/pwm_voice.sv
// One square-wave voice: shadowed control word, phase counter and toggle.
module pwm_voice
   import pwm_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic [CTRL_W-1:0] ctrl,
   output logic              wave
);

   logic [CTRL_W-1:0] shadow;
   logic [HP_W-1:0]   phase;
   logic              active;
   logic              at_end;

   assign active = ctrl_active(shadow);
   assign at_end = (phase == (shadow[HP_MSB:HP_LSB] - HP_W'(1)));

   // Advance on each tick; the shadow only reloads at a half-cycle boundary
   // or while idle, so period changes never cut a half-cycle short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow <= '0;
         phase  <= '0;
         wave   <= 1'b0;
      end else if (tick) begin
         if (!active) begin
            phase  <= '0;
            wave   <= 1'b0;
            shadow <= ctrl;
         end else if (at_end) begin
            phase  <= '0;
            wave   <= ~wave;
            shadow <= ctrl;
         end else begin
            phase  <= phase + HP_W'(1);
         end
      end
   end

endmodule

// File: rtl/pwm_voice_bank.sv
// Eight PWM-register driven tone voices mixed into one PWM audio pin.
module pwm_voice_bank
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = 100,
   parameter int unsigned FRAME    = FRAME_SLOTS
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CTRL_W-1:0]     pwm_reg0,
   input  logic [CTRL_W-1:0]     pwm_reg1,
   input  logic [CTRL_W-1:0]     pwm_reg2,
   input  logic [CTRL_W-1:0]     pwm_reg3,
   input  logic [CTRL_W-1:0]     pwm_reg4,
   input  logic [CTRL_W-1:0]     pwm_reg5,
   input  logic [CTRL_W-1:0]     pwm_reg6,
   input  logic [CTRL_W-1:0]     pwm_reg7,
   output logic [NUM_VOICES-1:0] voice_out,
   output logic [LEVEL_W-1:0]    mix_level,
   output logic                  tick,
   output logic                  audio_pwm
);

   localparam int unsigned SLOT_W   = $clog2(FRAME);
   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME - 1);

   logic [15:0]         pre_cnt;
   logic [15:0]         pre_next;
   logic [CTRL_W-1:0]   ctrl [NUM_VOICES];
   logic [SLOT_W-1:0]   slot;
   logic [LEVEL_W-1:0]  level_latched;

   assign ctrl[0] = pwm_reg0;
   assign ctrl[1] = pwm_reg1;
   assign ctrl[2] = pwm_reg2;
   assign ctrl[3] = pwm_reg3;
   assign ctrl[4] = pwm_reg4;
   assign ctrl[5] = pwm_reg5;
   assign ctrl[6] = pwm_reg6;
   assign ctrl[7] = pwm_reg7;

   // Next prescaler count, wrapping after PRESCALE-1.
   always_comb begin
      pre_next = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 16'd1;
   end

   // Prescaler; tick is registered so it is high exactly while the count sits at PRESCALE-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         pre_cnt <= pre_next;
         tick    <= (pre_next == PRE_LAST);
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      pwm_voice u_voice (
         .clk  (clk),
         .rst  (rst),
         .tick (tick),
         .ctrl (ctrl[g]),
         .wave (voice_out[g])
      );
   end

   // Mixer: count of high voices, one clk behind voice_out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mix_level <= '0;
      end else begin
         mix_level <= count_high(voice_out);
      end
   end

   // Output modulator: level is frozen at the last slot and used for the whole next frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot          <= '0;
         level_latched <= '0;
         audio_pwm     <= 1'b0;
      end else begin
         slot      <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
         audio_pwm <= (LEVEL_W'(slot) < level_latched);
         if (slot == SLOT_LAST) begin
            level_latched <= mix_level;
         end
      end
   end

endmodule
